// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C EEPROM target.
// Contents: the target's FSM state enum, the ACK/NAK bit levels,
// and the index of the R/W bit within the control byte.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CTRL,
        CTRL_ACK,
        ADDR_HI,
        ADDR_HI_ACK,
        ADDR_LO,
        ADDR_LO_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK_IN
    } i2c_state_e;

    localparam logic I2C_ACK = 1'b0;
    localparam logic I2C_NAK = 1'b1;
    localparam int   RW_BIT  = 0;

endpackage

// File: rtl/i2c_eeprom_slave_if.sv
// I2C pin bundle for the EEPROM target.
//   i2c_SCL_i / i2c_SDA_i : sampled line levels (asynchronous to clk)
//   i2c_SDA_e             : SDA output enable, 1 = pull the line
//   i2c_SDA_o             : SDA drive value (open-drain, always 0)
interface i2c_eeprom_slave_if;
    logic i2c_SCL_i;
    logic i2c_SDA_i;
    logic i2c_SDA_e;
    logic i2c_SDA_o;

    modport slave  (input  i2c_SCL_i, i2c_SDA_i, output i2c_SDA_e, i2c_SDA_o);
    modport master (output i2c_SCL_i, i2c_SDA_i, input  i2c_SDA_e, i2c_SDA_o);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronises SCL/SDA into clk and derives bus events.
//   clk, rst          : system clock, synchronous active-high reset
//   scl_i, sda_i      : raw line samples
//   scl_rise/scl_fall : one-clk SCL edge pulses
//   start/stop        : one-clk START / STOP pulses (SDA edge while SCL high)
//   sda               : synchronised SDA, aligned with the event pulses
// Events appear 3 clk after the pin change (2 sync flops + registered event).
module i2c_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop,
    output logic sda
);

    logic [1:0] scl_sy, sda_sy;
    logic       scl_p, sda_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Idle bus level so leaving reset produces no phantom events.
            scl_sy   <= 2'b11;
            sda_sy   <= 2'b11;
            scl_p    <= 1'b1;
            sda_p    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
            sda      <= 1'b1;
        end else begin
            scl_sy   <= {scl_sy[0], scl_i};
            sda_sy   <= {sda_sy[0], sda_i};
            scl_p    <= scl_sy[1];
            sda_p    <= sda_sy[1];
            scl_rise <=  scl_sy[1] & ~scl_p;
            scl_fall <= ~scl_sy[1] &  scl_p;
            start    <=  scl_sy[1] &  scl_p &  sda_p & ~sda_sy[1];
            stop     <=  scl_sy[1] &  scl_p & ~sda_p &  sda_sy[1];
            sda      <=  sda_sy[1];
        end
    end

endmodule

// File: rtl/i2c_eeprom_slave.sv
// I2C target emulating a 24LC32A-style EEPROM backed by an internal byte RAM.
//   clk, rst  : system clock, synchronous active-high reset
//   bus       : I2C pins (slave modport); SCL is never driven
//   busy      : high from the addressed control-byte ACK until the transfer ends
//   wr_valid  : one-clk pulse per byte committed to RAM
//   wr_addr   : RAM address of the committed byte
//   wr_data   : committed byte
module i2c_eeprom_slave
    import i2c_pkg::*;
#(
    parameter int         AWIDTH   = 10,
    parameter logic [6:0] SLV_ADDR = 7'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_eeprom_slave_if.slave     bus,
    output logic                  busy,
    output logic                  wr_valid,
    output logic [AWIDTH-1:0]     wr_addr,
    output logic [7:0]            wr_data
);

    logic scl_rise, scl_fall, start, stop, sda;

    i2c_line_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (bus.i2c_SCL_i),
        .sda_i    (bus.i2c_SDA_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop),
        .sda      (sda)
    );

    i2c_state_e        state, state_nx;
    logic [3:0]        cnt, cnt_nx;       // bits received, or bits driven in RD_BYTE
    logic [7:0]        sh, sh_nx;         // rx shift register / tx byte being sent
    logic [7:0]        hi, hi_nx;         // high word-address byte
    logic [AWIDTH-1:0] ptr, ptr_nx;
    logic              ack_drv, ack_nx;   // ACK slot already being driven
    logic              sda_e, sda_e_nx;
    logic              wr_en;
    logic [7:0]        byte_in;
    logic [7:0]        rd_data;
    logic [7:0]        mem [2**AWIDTH];

    assign byte_in = {sh[6:0], sda};

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sh_nx    = sh;
        hi_nx    = hi;
        ptr_nx   = ptr;
        ack_nx   = ack_drv;
        sda_e_nx = sda_e;
        wr_en    = 1'b0;
        if (stop) begin
            state_nx = IDLE;
            sda_e_nx = 1'b0;
        end else if (start) begin
            state_nx = CTRL;
            cnt_nx   = 4'd0;
            sda_e_nx = 1'b0;
        end else begin
            case (state)
                IDLE: ;
                CTRL, ADDR_HI, ADDR_LO, WR_BYTE: begin
                    if (scl_rise) begin
                        sh_nx  = byte_in;
                        cnt_nx = cnt + 4'd1;
                        ack_nx = 1'b0;
                        if (cnt == 4'd7) begin
                            cnt_nx = 4'd0;
                            case (state)
                                CTRL:    state_nx = (byte_in[7:1] == SLV_ADDR) ? CTRL_ACK : IDLE;
                                ADDR_HI: begin
                                    hi_nx    = byte_in;
                                    state_nx = ADDR_HI_ACK;
                                end
                                ADDR_LO: begin
                                    ptr_nx   = AWIDTH'({hi, byte_in});
                                    state_nx = ADDR_LO_ACK;
                                end
                                default: begin
                                    wr_en    = ~rst;
                                    ptr_nx   = ptr + AWIDTH'(1);
                                    state_nx = WR_ACK;
                                end
                            endcase
                        end
                    end
                end
                CTRL_ACK, ADDR_HI_ACK, ADDR_LO_ACK, WR_ACK: begin
                    // First fall after the 8th bit pulls SDA; the next one releases it.
                    if (scl_fall) begin
                        if (!ack_drv) begin
                            sda_e_nx = 1'b1;
                            ack_nx   = 1'b1;
                        end else begin
                            sda_e_nx = 1'b0;
                            cnt_nx   = 4'd0;
                            case (state)
                                CTRL_ACK: begin
                                    if (sh[RW_BIT]) begin
                                        // rd_data already holds RAM[ptr]; put out its MSB now.
                                        state_nx = RD_BYTE;
                                        sh_nx    = rd_data;
                                        sda_e_nx = ~rd_data[7];
                                        cnt_nx   = 4'd1;
                                    end else begin
                                        state_nx = ADDR_HI;
                                    end
                                end
                                ADDR_HI_ACK: state_nx = ADDR_LO;
                                default:     state_nx = WR_BYTE;
                            endcase
                        end
                    end
                end
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (cnt == 4'd0) begin
                            sh_nx    = rd_data;
                            sda_e_nx = ~rd_data[7];
                            cnt_nx   = 4'd1;
                        end else if (cnt == 4'd8) begin
                            sda_e_nx = 1'b0;
                            cnt_nx   = 4'd0;
                            state_nx = RD_ACK_IN;
                        end else begin
                            sh_nx    = {sh[6:0], 1'b0};
                            sda_e_nx = ~sh[6];
                            cnt_nx   = cnt + 4'd1;
                        end
                    end
                end
                RD_ACK_IN: begin
                    if (scl_rise) begin
                        if (sda == I2C_ACK) begin
                            ptr_nx   = ptr + AWIDTH'(1);
                            cnt_nx   = 4'd0;
                            state_nx = RD_BYTE;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            sh       <= 8'd0;
            hi       <= 8'd0;
            ptr      <= '0;
            ack_drv  <= 1'b0;
            sda_e    <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            sh       <= sh_nx;
            hi       <= hi_nx;
            ptr      <= ptr_nx;
            ack_drv  <= ack_nx;
            sda_e    <= sda_e_nx;
            wr_valid <= wr_en;
            if (wr_en) begin
                wr_addr <= ptr;
                wr_data <= byte_in;
            end
        end
    end

    // Single-port RAM, contents survive reset. The read is continuous so
    // the next byte is ready well before the SCL fall that starts sending it.
    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr] <= byte_in;
        rd_data <= mem[ptr];
    end

    assign busy          = (state != IDLE) && (state != CTRL);
    assign bus.i2c_SDA_e = sda_e;
    assign bus.i2c_SDA_o = 1'b0;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
module tb_i2c_eeprom_slave;

    localparam int AW = 10;
    localparam int H  = 8;     // SCL half period in clk

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_eeprom_slave_if i2c ();
    logic          busy, wr_valid;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          scl_m = 1'b1, sda_m = 1'b1;

    assign i2c.i2c_SCL_i = scl_m;
    assign i2c.i2c_SDA_i = sda_m & ~(i2c.i2c_SDA_e & ~i2c.i2c_SDA_o);

    i2c_eeprom_slave #(.AWIDTH(AW), .SLV_ADDR(7'd1)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (i2c.slave),
        .busy     (busy),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    int n_vec = 0, n_miss = 0;

    // write-commit monitor (only this block writes these)
    logic [AW+7:0] got_q[$];
    int            sda_e_cnt = 0;
    always @(negedge clk) begin
        if (wr_valid) got_q.push_back({wr_addr, wr_data});
        if (i2c.i2c_SDA_e) sda_e_cnt++;
    end

    logic [AW+7:0] exp_q[$];
    int            got_rd = 0;
    logic [7:0]    model [2**AW];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic sb_check(input string nm);
        int n;
        n = got_q.size() - got_rd;
        chk({nm, " wr count"}, n, exp_q.size());
        foreach (exp_q[i])
            if (i < n) chk($sformatf("%s wr[%0d]", nm, i), 32'(got_q[got_rd+i]), 32'(exp_q[i]));
        got_rd = got_q.size();
        exp_q.delete();
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wbit(input logic b);
        tick(2); sda_m = b; tick(H-2); scl_m = 1'b1; tick(H); scl_m = 1'b0;
    endtask

    task automatic rbit(output logic b);
        tick(2); sda_m = 1'b1; tick(H-2); scl_m = 1'b1; tick(H/2);
        b = i2c.i2c_SDA_i;
        tick(H/2); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            tick(2); sda_m = 1'b1; tick(H-2); scl_m = 1'b1; tick(H);
        end
        sda_m = 1'b0; tick(H); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        tick(2); sda_m = 1'b0; tick(H-2); scl_m = 1'b1; tick(H); sda_m = 1'b1; tick(H);
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        rbit(ack);
    endtask

    task automatic rbyte(input logic mack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(mack);
    endtask

    // Full write transaction; with exp_ack = NAK every byte must go unacknowledged.
    task automatic write_txn(input logic [7:0] ctrl, input logic [15:0] a,
                             input logic [7:0] d[$], input logic exp_ack, input string nm);
        logic          ack;
        logic [AW-1:0] p;
        i2c_start();
        wbyte(ctrl, ack);    chk({nm, " ctrl ack"}, 32'(ack), 32'(exp_ack));
        wbyte(a[15:8], ack); chk({nm, " hi ack"},   32'(ack), 32'(exp_ack));
        wbyte(a[7:0], ack);  chk({nm, " lo ack"},   32'(ack), 32'(exp_ack));
        p = a[AW-1:0];
        foreach (d[i]) begin
            wbyte(d[i], ack);
            chk($sformatf("%s data ack %0d", nm, i), 32'(ack), 32'(exp_ack));
            if (exp_ack == 1'b0) begin
                exp_q.push_back({p, d[i]});
                model[p] = d[i];
                p = p + 1'b1;
            end
        end
        i2c_stop();
        sb_check(nm);
    endtask

    // Random read: address write, repeated START, n bytes, NAK on the last.
    task automatic read_txn(input logic [15:0] a, input int n, input string nm);
        logic          ack;
        logic [7:0]    d;
        logic [AW-1:0] p;
        i2c_start();
        wbyte(8'h02, ack);   chk({nm, " rd ctrl ack"}, 32'(ack), 0);
        wbyte(a[15:8], ack); chk({nm, " rd hi ack"},   32'(ack), 0);
        wbyte(a[7:0], ack);  chk({nm, " rd lo ack"},   32'(ack), 0);
        i2c_start();
        wbyte(8'h03, ack);   chk({nm, " rd ctrl2 ack"}, 32'(ack), 0);
        p = a[AW-1:0];
        for (int i = 0; i < n; i++) begin
            rbyte((i == n-1) ? 1'b1 : 1'b0, d);
            chk($sformatf("%s rd[%0d]", nm, i), 32'(d), 32'(model[p]));
            p = p + 1'b1;
        end
        chk({nm, " sda released"}, 32'(i2c.i2c_SDA_e), 0);
        i2c_stop();
    endtask

    typedef struct {
        logic [7:0]  ctrl;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        exp_ack;
    } vec_t;

    vec_t vt[6];

    initial begin
        logic [7:0] q[$];
        logic       ack;
        int         e0;

        vt[0] = '{8'h02, 16'h0005, 8'hA5, 1'b0};
        vt[1] = '{8'h02, 16'h0200, 8'h3C, 1'b0};
        vt[2] = '{8'h02, 16'hFE10, 8'h0F, 1'b0};   // upper bits dropped -> 0x210
        vt[3] = '{8'h06, 16'h0007, 8'h99, 1'b1};   // device address 3
        vt[4] = '{8'h02, 16'h03FE, 8'hFF, 1'b0};
        vt[5] = '{8'h00, 16'h0001, 8'h11, 1'b1};   // device address 0

        // reset state
        tick(4);
        chk("rst sda_e",    32'(i2c.i2c_SDA_e), 0);
        chk("rst busy",     32'(busy), 0);
        chk("rst wr_valid", 32'(wr_valid), 0);
        chk("rst wr_addr",  32'(wr_addr), 0);
        chk("rst wr_data",  32'(wr_data), 0);
        rst = 1'b0;
        tick(4);

        // table: single-byte write then read-back for addressed rows
        foreach (vt[k]) begin
            q = {};
            q.push_back(vt[k].data);
            e0 = sda_e_cnt;
            write_txn(vt[k].ctrl, vt[k].addr, q, vt[k].exp_ack, $sformatf("vec%0d", k));
            if (vt[k].exp_ack == 1'b1)
                chk($sformatf("vec%0d sda quiet", k), sda_e_cnt - e0, 0);
            else
                read_txn(vt[k].addr, 1, $sformatf("vec%0d", k));
        end

        // 4-byte sequential write and random read
        q = {8'h12, 8'h34, 8'h56, 8'h78};
        write_txn(8'h02, 16'h0123, q, 1'b0, "wr4");
        read_txn(16'h0123, 4, "rd4");

        // foreign device address: no ACK anywhere, RAM untouched
        e0 = sda_e_cnt;
        q = {8'hEE};
        write_txn(8'h04, 16'h0123, q, 1'b1, "addr2");
        chk("addr2 sda quiet", sda_e_cnt - e0, 0);
        read_txn(16'h0123, 1, "addr2 ram");

        // pointer wrap at top of RAM
        q = {8'hAA, 8'hBB, 8'hCC};
        write_txn(8'h02, 16'h03FF, q, 1'b0, "wrap");
        read_txn(16'h03FF, 3, "wrap");

        // STOP in the middle of a data byte
        i2c_start();
        wbyte(8'h02, ack); wbyte(8'h00, ack); wbyte(8'h10, ack);
        for (int i = 7; i >= 4; i--) wbit(1'b1);
        i2c_stop();
        sb_check("partial");
        chk("partial busy", 32'(busy), 0);
        q = {8'h5A};
        write_txn(8'h02, 16'h0010, q, 1'b0, "after partial");
        read_txn(16'h0010, 1, "after partial");

        // reset while the target drives a 0 data bit
        i2c_start();
        wbyte(8'h02, ack); wbyte(8'h01, ack); wbyte(8'h23, ack);
        i2c_start();
        wbyte(8'h03, ack);
        chk("rstrd ctrl ack", 32'(ack), 0);
        tick(6);
        chk("rstrd driving", 32'(i2c.i2c_SDA_e), 1);
        chk("rstrd busy",    32'(busy), 1);
        rst = 1'b1;
        tick(1);
        chk("rstrd sda_e", 32'(i2c.i2c_SDA_e), 0);
        chk("rstrd busy0", 32'(busy), 0);
        rst = 1'b0;
        i2c_stop();
        read_txn(16'h0123, 4, "post rst");
        sb_check("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
